// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Single-port framebuffer arbiter. It sits between the VGA scan-out fetcher,
//   a drawing client and a built-in frame-clear engine. Each cycle it grants at
//   most one RAM access. Scan-out reads always win. Writes are blocked while a
//   clear is running, so draws land after the fill.
//
// Ports
//   VGA_CLK, RESET_N            pixel clock, async active-low reset
//   rd_req/rd_addr              scan-out read request (held until granted)
//   rd_gnt                      read issued this cycle (combinational)
//   rd_valid/rd_data            read result, one cycle after rd_gnt
//   wr_req/wr_addr/wr_data      drawing-client write request
//   wr_gnt                      write accepted this cycle (combinational)
//   clr_start/clr_color         start a frame fill with clr_color
//   clr_busy/clr_done           fill in progress / last fill write issued
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         synchronous single-port RAM interface
module vga_fb_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12,
  parameter int FB_DEPTH = 480000
) (
  input  logic              VGA_CLK,
  input  logic              RESET_N,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] clr_color_q, clr_color_nxt;
  logic              clr_last;
  logic              rd_hit_q;
  logic              rd_in_range;
  logic              wr_in_range;

  assign rd_in_range = (rd_addr <= LAST_ADDR);
  assign wr_in_range = (wr_addr <= LAST_ADDR);

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      clr_color_q <= '0;
      rd_valid    <= 1'b0;
      rd_hit_q    <= 1'b0;
      clr_done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_cnt_nxt;
      clr_color_q <= clr_color_nxt;
      rd_valid    <= rd_gnt;
      // Out-of-range reads never strobe the RAM, so their result is forced to 0.
      rd_hit_q    <= rd_gnt & rd_in_range;
      clr_done    <= clr_last;
    end
  end

  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    clr_color_nxt = clr_color_q;
    clr_last      = 1'b0;
    rd_gnt        = 1'b0;
    wr_gnt        = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    if (rd_req) begin
      rd_gnt   = 1'b1;
      mem_en   = rd_in_range;
      mem_addr = rd_addr;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_req) begin
            // Out-of-range writes are acknowledged but never reach the RAM.
            wr_gnt    = 1'b1;
            mem_en    = wr_in_range;
            mem_we    = wr_in_range;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
          end
        end
        CLEAR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = clr_cnt;
          mem_wdata = clr_color_q;
          if (clr_cnt == LAST_ADDR) begin
            clr_last    = 1'b1;
            clr_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            clr_cnt_nxt = clr_cnt + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end

    // The start cycle itself still arbitrates as IDLE; the fill begins next cycle.
    if (state == IDLE && clr_start) begin
      state_nxt     = CLEAR;
      clr_cnt_nxt   = '0;
      clr_color_nxt = clr_color;
    end
  end

  assign clr_busy = (state == CLEAR);
  assign rd_data  = rd_hit_q ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 2000;

  logic              clk = 1'b0;
  logic              RESET_N;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] ram  [0:DEPTH-1] = '{default: '0};
  int                wcnt [0:DEPTH-1] = '{default: 0};
  int                base [0:DEPTH-1];

  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(DEPTH)) dut (
    .VGA_CLK(clk), .RESET_N(RESET_N),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM model with per-address write counters.
  always @(posedge clk) begin
    if (mem_en && int'(mem_addr) < DEPTH) begin
      if (mem_we) begin
        ram[mem_addr[10:0]]  <= mem_wdata;
        wcnt[mem_addr[10:0]] <= wcnt[mem_addr[10:0]] + 1;
      end else begin
        mem_rdata <= ram[mem_addr[10:0]];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    RESET_N = 1'b0; rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0;
    wr_data = '0; clr_start = 0; clr_color = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({rd_valid, rd_data, clr_busy, clr_done, mem_en, mem_we} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%h/%b/%b/%b/%b exp=all zero",
               rd_valid, rd_data, clr_busy, clr_done, mem_en, mem_we);
    end
    @(negedge clk) RESET_N = 1'b1;
    @(negedge clk) #1;
    checks++;
    if ({rd_gnt, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata, rd_valid, clr_busy} !== '0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b %b %b %b %h %h %b %b exp=all zero",
               rd_gnt, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata, rd_valid, clr_busy);
    end
  endtask

  task automatic test_read();
    @(negedge clk) wr_req = 1; wr_addr = 5; wr_data = 12'hABC;
    #1;
    checks++;
    if ({wr_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 19'd5, 12'hABC}) begin
      failures++;
      $display("FAIL write_grant got=%b%b%b %h %h exp=111 5 abc", wr_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk) wr_addr = 6; wr_data = 12'h5A5;
    @(negedge clk) wr_req = 0; rd_req = 1; rd_addr = 5;
    #1;
    checks++;
    if ({rd_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 19'd5}) begin
      failures++;
      $display("FAIL read_grant got=%b%b%b %h exp=110 5", rd_gnt, mem_en, mem_we, mem_addr);
    end
    @(negedge clk) rd_addr = 6;
    #1;
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, 12'hABC}) begin
      failures++;
      $display("FAIL read_data_5 got=%b %h exp=1 abc", rd_valid, rd_data);
    end
    @(negedge clk) rd_req = 0;
    #1;
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, 12'h5A5}) begin
      failures++;
      $display("FAIL read_b2b_6 got=%b %h exp=1 5a5", rd_valid, rd_data);
    end
    @(negedge clk) #1;
    checks++;
    if ({rd_valid, rd_data} !== 13'd0) begin
      failures++;
      $display("FAIL read_idle got=%b %h exp=0 000", rd_valid, rd_data);
    end
  endtask

  task automatic test_priority();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk) rd_req = 1; rd_addr = 6; wr_req = 1; wr_addr = 100; wr_data = 12'h3C7;
      #1;
      checks++;
      if ({rd_gnt, wr_gnt, mem_we} !== 3'b100) begin
        failures++;
        $display("FAIL prio_cycle%0d got=rd%b wr%b we%b exp=rd1 wr0 we0", c, rd_gnt, wr_gnt, mem_we);
      end
    end
    @(negedge clk) rd_req = 0;
    #1;
    checks++;
    if ({wr_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 19'd100, 12'h3C7}) begin
      failures++;
      $display("FAIL prio_write got=%b%b%b %h %h exp=111 64 3c7", wr_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk) wr_req = 0; rd_req = 1; rd_addr = 100;
    @(negedge clk) rd_req = 0;
    #1;
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, 12'h3C7}) begin
      failures++;
      $display("FAIL prio_readback got=%b %h exp=1 3c7", rd_valid, rd_data);
    end
  endtask

  task automatic test_clear_full();
    int busy = 0, early = 0, dones = 0, bad = 0;
    for (int i = 0; i < DEPTH; i++) base[i] = wcnt[i];
    @(negedge clk) clr_start = 1; clr_color = 12'hF00;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_start_cycle_busy got=%b exp=0", clr_busy);
    end
    @(negedge clk) clr_start = 0; clr_color = 12'h777; wr_req = 1; wr_addr = 10; wr_data = 12'h0AA;
    #1;
    checks++;
    if ({clr_busy, mem_we, mem_addr, mem_wdata} !== {2'b11, 19'd0, 12'hF00}) begin
      failures++;
      $display("FAIL clear_first_slot got=%b%b %h %h exp=11 0 f00", clr_busy, mem_we, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (!clr_busy) break;
      busy++;
      if (wr_gnt) early++;
      if (clr_done) dones++;
      @(negedge clk) #1;
    end
    checks++;
    if (busy != DEPTH || early != 0 || dones != 0) begin
      failures++;
      $display("FAIL clear_duration got=busy%0d wrgnt%0d done%0d exp=busy%0d wrgnt0 done0", busy, early, dones, DEPTH);
    end
    checks++;
    if ({clr_done, wr_gnt, mem_addr} !== {2'b11, 19'd10}) begin
      failures++;
      $display("FAIL clear_done_edge got=done%b wrgnt%b addr%h exp=done1 wrgnt1 addr a", clr_done, wr_gnt, mem_addr);
    end
    @(negedge clk) wr_req = 0;
    #1;
    checks++;
    if (clr_done !== 1'b0) begin
      failures++;
      $display("FAIL clear_done_width got=%b exp=0", clr_done);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ram[i] !== ((i == 10) ? 12'h0AA : 12'hF00) || wcnt[i] - base[i] != ((i == 10) ? 2 : 1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clear_contents got=%0d bad locations exp=0", bad);
    end
  endtask

  task automatic test_clear_pause();
    int busy = 0, reads = 0, rdv = 0, dones = 0, bad = 0, rdwe = 0;
    logic [ADDR_W-1:0] a_before = '0, a_after = '0;
    for (int i = 0; i < DEPTH; i++) base[i] = wcnt[i];
    @(negedge clk) clr_start = 1; clr_color = 12'h00F;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      @(negedge clk);
      clr_start = (i == 200);
      clr_color = (i == 200) ? 12'h0F0 : 12'h00F;
      rd_req    = (i >= 100 && i < 110);
      rd_addr   = 1990;
      #1;
      if (!clr_busy) break;
      busy++;
      if (rd_gnt) reads++;
      if (rd_gnt && mem_we) rdwe++;
      if (rd_valid) rdv++;
      if (clr_done) dones++;
      if (i == 99)  a_before = mem_addr;
      if (i == 110) a_after  = mem_addr;
    end
    checks++;
    if (busy != DEPTH + 10 || reads != 10 || rdv != 10 || rdwe != 0 || dones != 0) begin
      failures++;
      $display("FAIL pause_counts got=busy%0d rd%0d valid%0d rdwe%0d done%0d exp=busy%0d rd10 valid10 rdwe0 done0",
               busy, reads, rdv, rdwe, dones, DEPTH + 10);
    end
    checks++;
    if (a_before !== 19'd99 || a_after !== 19'd100) begin
      failures++;
      $display("FAIL pause_resume got=%0d->%0d exp=99->100", a_before, a_after);
    end
    checks++;
    if (clr_done !== 1'b1) begin
      failures++;
      $display("FAIL pause_done got=%b exp=1", clr_done);
    end
    @(negedge clk) #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram[i] !== 12'h00F || wcnt[i] - base[i] != 1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL pause_contents got=%0d bad locations exp=0", bad);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk) rd_req = 1; rd_addr = 5;
    @(negedge clk) rd_addr = 480000;
    #1;
    checks++;
    if ({rd_gnt, mem_en, rd_valid, rd_data} !== {3'b101, 12'h00F}) begin
      failures++;
      $display("FAIL oor_read_grant got=gnt%b en%b valid%b data%h exp=gnt1 en0 valid1 data00f", rd_gnt, mem_en, rd_valid, rd_data);
    end
    @(negedge clk) rd_req = 0; wr_req = 1; wr_addr = 524287; wr_data = 12'hFFF;
    #1;
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, 12'h000}) begin
      failures++;
      $display("FAIL oor_read_data got=%b %h exp=1 000", rd_valid, rd_data);
    end
    checks++;
    if ({wr_gnt, mem_en, mem_we} !== 3'b100) begin
      failures++;
      $display("FAIL oor_write got=gnt%b en%b we%b exp=gnt1 en0 we0", wr_gnt, mem_en, mem_we);
    end
    @(negedge clk) wr_req = 0; rd_req = 1; rd_addr = DEPTH - 1;
    #1;
    checks++;
    if (mem_en !== 1'b1) begin
      failures++;
      $display("FAIL last_addr_in_range got=en%b exp=en1", mem_en);
    end
    @(negedge clk) rd_addr = DEPTH;
    #1;
    checks++;
    if ({mem_en, rd_data} !== {1'b0, 12'h00F}) begin
      failures++;
      $display("FAIL depth_addr got=en%b data%h exp=en0 data00f", mem_en, rd_data);
    end
    @(negedge clk) rd_req = 0;
    #1;
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, 12'h000}) begin
      failures++;
      $display("FAIL depth_addr_data got=%b %h exp=1 000", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_abort();
    bit found = 0;
    @(negedge clk) clr_start = 1; clr_color = 12'hABC;
    @(negedge clk) clr_start = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      #1;
      if (clr_busy && mem_we && mem_addr == 19'd1000) begin found = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL abort_reach_1000 got=not reached exp=reached");
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({clr_busy, clr_done, mem_en} !== 3'b000) begin
      failures++;
      $display("FAIL abort_immediate got=busy%b done%b en%b exp=000", clr_busy, clr_done, mem_en);
    end
    @(negedge clk) #1;
    checks++;
    if (clr_done !== 1'b0 || ram[999] !== 12'hABC || ram[1000] !== 12'h00F) begin
      failures++;
      $display("FAIL abort_partial got=done%b m999=%h m1000=%h exp=done0 abc 00f", clr_done, ram[999], ram[1000]);
    end
    RESET_N = 1'b1;
    @(negedge clk) clr_start = 1; clr_color = 12'h123;
    @(negedge clk) clr_start = 0;
    #1;
    checks++;
    if ({clr_busy, mem_we, mem_addr, mem_wdata} !== {2'b11, 19'd0, 12'h123}) begin
      failures++;
      $display("FAIL restart_addr0 got=%b%b %h %h exp=11 0 123", clr_busy, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk) rd_req = 1; rd_addr = 5;
    #1 RESET_N = 1'b0;
    @(negedge clk) rd_req = 0;
    #1;
    checks++;
    if ({rd_valid, rd_data, clr_busy} !== 14'd0) begin
      failures++;
      $display("FAIL reset_kills_read got=valid%b data%h busy%b exp=0 000 0", rd_valid, rd_data, clr_busy);
    end
    RESET_N = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_priority();
    test_clear_full();
    test_clear_pause();
    test_out_of_range();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
